// File: rtl/dp_pkg.sv
// Shared definitions for the data-processing issue/writeback slice:
// opcode and condition encodings, FSM state codes and the instruction word layout.
package dp_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam int COND_LSB   = 28;
    localparam int IMM_BIT    = 25;
    localparam int OPCODE_LSB = 21;
    localparam int S_BIT      = 20;
    localparam int RN_LSB     = 16;
    localparam int RD_LSB     = 12;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  rsvd;
        logic        imm;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] op2;
    } instr_t;

    // Compare/test opcodes (10xx) only update flags.
    function automatic logic writes_rd(input logic [3:0] op);
        return op[3:2] != 2'b10;
    endfunction

endpackage

// File: rtl/dp_issue_if.sv
// Instruction handshake plus operand/result bus between dp_issue and the ALU op units.
interface dp_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        en_inst;
    logic [3:0]  opcode;
    logic        IMM;
    logic        S;
    logic [31:0] Rn;
    logic [31:0] Rm;
    logic [11:0] imm_operand;
    logic [4:0]  imm_shift;
    logic [1:0]  stype;
    logic        carry_in;
    logic        zero_in;
    logic        neg_in;
    logic [31:0] Rd;
    logic        carry_out;
    logic        zero_out;
    logic        neg_out;

    modport master (
        input  instr_valid, instr, Rd, carry_out, zero_out, neg_out,
        output instr_ready, en_inst, opcode, IMM, S, Rn, Rm,
               imm_operand, imm_shift, stype, carry_in, zero_in, neg_in
    );

    modport slave (
        output instr_valid, instr, Rd, carry_out, zero_out, neg_out,
        input  instr_ready, en_inst, opcode, IMM, S, Rn, Rm,
               imm_operand, imm_shift, stype, carry_in, zero_in, neg_in
    );
endinterface

// File: rtl/dp_issue_cond_check.sv
// Condition-code evaluation against N/Z/C; V is not tracked and reads as 0.
module cond_check
    import dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    output logic       pass
);
    always_comb begin
        pass = 1'b1;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = 1'b0;
            CC_VC: pass = 1'b1;
            CC_HI: pass = c & !z;
            CC_LS: pass = !c | z;
            CC_GE: pass = !n;
            CC_LT: pass = n;
            CC_GT: pass = !z & !n;
            CC_LE: pass = z | n;
            default: pass = 1'b1;
        endcase
    end
endmodule

// File: rtl/dp_issue.sv
// Issue/writeback stage: 16x32 regfile, IDLE->READ->EXEC->WB sequencing and N/Z/C flags.
// Conditional execution is built only when DP_ISSUE_COND_EN is defined.
module dp_issue
    import dp_pkg::*;
#(
    parameter logic [31:0] REG_INIT = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    dp_issue_if.master        bus,
    input  logic [3:0]        dbg_addr,
    output logic [31:0]       dbg_data,
    output logic              pc_wr_err,
    output logic [15:0]       skip_cnt
);
    logic [1:0]  state_reg;
    instr_t      instr_reg;
    logic        en_reg;
    logic [3:0]  opcode_reg;
    logic        imm_reg;
    logic        s_reg;
    logic [31:0] rn_reg;
    logic [31:0] rm_reg;
    logic [11:0] op2_reg;
    logic        n_reg;
    logic        z_reg;
    logic        c_reg;
    logic        pc_err_reg;
    logic [31:0] rf_reg [16];
    logic        cond_pass;
    logic        wb_wr;
    logic [14:0] wr_sel;

    // R15 is never selected for writing, so its entry stays at its reset value of 0.
    assign wb_wr = (state_reg == ST_WB) && writes_rd(opcode_reg) && (instr_reg.rd != 4'hF);

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wb_wr && (instr_reg.rd == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_reg[i] <= (i == 15) ? 32'h0 : REG_INIT;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (wr_sel[i]) begin
                    rf_reg[i] <= bus.Rd;
                end
            end
        end
    end

`ifdef DP_ISSUE_COND_EN
    logic [15:0] skip_cnt_reg;

    cond_check u_cond_check (
        .cond (instr_reg.cond),
        .n    (n_reg),
        .z    (z_reg),
        .c    (c_reg),
        .pass (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt_reg <= '0;
        end else if ((state_reg == ST_READ) && !cond_pass && (skip_cnt_reg != 16'hFFFF)) begin
            skip_cnt_reg <= skip_cnt_reg + 16'd1;
        end
    end

    assign skip_cnt = skip_cnt_reg;
`else
    assign cond_pass = 1'b1;
    assign skip_cnt  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            instr_reg  <= '0;
            en_reg     <= 1'b0;
            opcode_reg <= '0;
            imm_reg    <= 1'b0;
            s_reg      <= 1'b0;
            rn_reg     <= '0;
            rm_reg     <= '0;
            op2_reg    <= '0;
            n_reg      <= 1'b0;
            z_reg      <= 1'b0;
            c_reg      <= 1'b0;
            pc_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_reg <= bus.instr;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    // A failed condition leaves every operand output untouched.
                    if (cond_pass) begin
                        opcode_reg <= instr_reg.opcode;
                        imm_reg    <= instr_reg.imm;
                        s_reg      <= instr_reg.s;
                        rn_reg     <= rf_reg[instr_reg.rn];
                        rm_reg     <= rf_reg[instr_reg.op2[3:0]];
                        op2_reg    <= instr_reg.op2;
                        en_reg     <= 1'b1;
                        state_reg  <= ST_EXEC;
                    end else begin
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    en_reg    <= 1'b0;
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    n_reg <= bus.neg_out;
                    z_reg <= bus.zero_out;
                    c_reg <= bus.carry_out;
                    if (writes_rd(opcode_reg) && (instr_reg.rd == 4'hF)) begin
                        pc_err_reg <= 1'b1;
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_reg == ST_IDLE);
    assign bus.en_inst     = en_reg;
    assign bus.opcode      = opcode_reg;
    assign bus.IMM         = imm_reg;
    assign bus.S           = s_reg;
    assign bus.Rn          = rn_reg;
    assign bus.Rm          = rm_reg;
    assign bus.imm_operand = op2_reg;
    assign bus.imm_shift   = op2_reg[11:7];
    assign bus.stype       = op2_reg[6:5];
    assign bus.carry_in    = c_reg;
    assign bus.zero_in     = z_reg;
    assign bus.neg_in      = n_reg;

    assign dbg_data  = rf_reg[dbg_addr];
    assign pc_wr_err = pc_err_reg;

endmodule

// File: tb/tb_dp_issue.sv
// Self-checking bench for dp_issue: directed table, hand sequences for reset-in-flight,
// and randomized instructions checked against a register/flag model.
module tb_dp_issue;
    import dp_pkg::*;

    localparam logic [31:0] INIT = 32'h1234_5678;
`ifdef DP_ISSUE_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        pc_wr_err;
    logic [15:0] skip_cnt;

    always #5 clk = ~clk;

    dp_issue_if bus ();

    dp_issue #(.REG_INIT(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .pc_wr_err (pc_wr_err),
        .skip_cnt  (skip_cnt)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        n;
        logic        z;
        logic        c;
    } alu_t;

    // Behaviour of the downstream op units: 33-bit arithmetic, flags only when S is set.
    function automatic alu_t alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic n_in, input logic z_in, input logic c_in);
        logic [32:0] t;
        alu_t o;
        case (op)
            4'h0, 4'h8: t = {c_in, a & b};
            4'h1, 4'h9: t = {c_in, a ^ b};
            4'h2, 4'hA: t = {1'b0, a} + {1'b0, ~b} + 33'd1;
            4'h3:       t = {1'b0, b} + {1'b0, ~a} + 33'd1;
            4'h4, 4'hB: t = {1'b0, a} + {1'b0, b};
            4'h5:       t = {1'b0, a} + {1'b0, b} + 33'(c_in);
            4'h6:       t = {1'b0, a} + {1'b0, ~b} + 33'(c_in);
            4'h7:       t = {1'b0, b} + {1'b0, ~a} + 33'(c_in);
            4'hC:       t = {c_in, a | b};
            4'hD:       t = {c_in, b};
            4'hE:       t = {c_in, a & ~b};
            default:    t = {c_in, ~b};
        endcase
        o.r = t[31:0];
        if (s) begin
            o.n = t[31];
            o.z = (t[31:0] == 32'h0);
            o.c = t[32];
        end else begin
            o.n = n_in;
            o.z = z_in;
            o.c = c_in;
        end
        return o;
    endfunction

    function automatic logic [31:0] op2_f(input logic imm, input logic [11:0] imm12,
                                          input logic [31:0] rm, input logic [4:0] sh);
        return imm ? {20'h0, imm12} : (rm << sh);
    endfunction

    alu_t stub_o;
    always_comb begin
        stub_o = alu_f(bus.opcode, bus.Rn, op2_f(bus.IMM, bus.imm_operand, bus.Rm, bus.imm_shift),
                       bus.S, bus.neg_in, bus.zero_in, bus.carry_in);
        bus.Rd        = stub_o.r;
        bus.neg_out   = stub_o.n;
        bus.zero_out  = stub_o.z;
        bus.carry_out = stub_o.c;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_rf [16];
    logic        m_n, m_z, m_c, m_err;
    int          m_skip;

    function automatic bit cond_ok(input logic [3:0] cc, input logic n, input logic z, input logic c);
        if (!COND_EN) return 1'b1;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return 1'b0;
            4'd7:  return 1'b1;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return !n;
            4'd11: return n;
            4'd12: return !z && !n;
            4'd13: return z || n;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_rf[i] = INIT;
        m_rf[15] = 32'h0;
        m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
        m_skip = 0;
    endtask

    function automatic logic [31:0] enc(input logic [3:0] cc, input logic i, input logic [3:0] op,
                                        input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] o2);
        return {cc, 2'b00, i, op, s, rn, rd, o2};
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    int txn = 0;

    // Issue one word from IDLE; returns at the negedge where instr_ready is back.
    task automatic run(input logic [31:0] w);
        logic [3:0]  cc, op, rn, rd;
        logic        iflag, s;
        logic [11:0] o2;
        logic [31:0] exp_rn, exp_rm;
        alu_t        res;
        bit          exp_exec;
        int          en_cnt, en_first, rdy_k;
        cc = w[31:28]; iflag = w[25]; op = w[24:21]; s = w[20];
        rn = w[19:16]; rd = w[15:12]; o2 = w[11:0];
        exp_exec = cond_ok(cc, m_n, m_z, m_c);
        exp_rn = m_rf[rn];
        exp_rm = m_rf[o2[3:0]];
        res = alu_f(op, exp_rn, op2_f(iflag, o2, exp_rm, o2[11:7]), s, m_n, m_z, m_c);

        chk("ready_before_issue", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr = w;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        bus.instr = $urandom;
        en_cnt = 0; en_first = 0; rdy_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.en_inst) begin
                en_cnt++;
                if (en_first == 0) en_first = k;
                chk("op_Rn", bus.Rn, exp_rn);
                chk("op_Rm", bus.Rm, exp_rm);
                chk("op_opcode", 32'(bus.opcode), 32'(op));
                chk("op_imm12", 32'(bus.imm_operand), 32'(o2));
                chk("op_IMM_S", 32'({bus.IMM, bus.S}), 32'({iflag, s}));
            end
            if (bus.instr_ready) begin
                rdy_k = k;
                break;
            end
        end
        if (rdy_k == 0) $display("FAIL ready_timeout actual=none required=%0d", exp_exec ? 4 : 2);
        chk("en_pulses", 32'(en_cnt), exp_exec ? 32'd1 : 32'd0);
        if (exp_exec) chk("en_cycle", 32'(en_first), 32'd2);
        chk("ready_cycle", 32'(rdy_k), exp_exec ? 32'd4 : 32'd2);

        if (exp_exec) begin
            m_n = res.n; m_z = res.z; m_c = res.c;
            if (op[3:2] != 2'b10) begin
                if (rd == 4'hF) m_err = 1'b1;
                else m_rf[rd] = res.r;
            end
        end else if (m_skip < 65535) begin
            m_skip++;
        end

        dbg_addr = rd;
        #1;
        chk("rf_rd", dbg_data, m_rf[rd]);
        chk("flags_nzc", 32'({bus.neg_in, bus.zero_in, bus.carry_in}), 32'({m_n, m_z, m_c}));
        chk("skip_cnt", 32'(skip_cnt), 32'(m_skip));
        chk("pc_wr_err", 32'(pc_wr_err), 32'(m_err));
        txn++;
        $display("txn %0d instr=%h exec=%0d rd=R%0d val=%h nzc=%b skip=%0d err=%0d",
                 txn, w, exp_exec, rd, dbg_data, {bus.neg_in, bus.zero_in, bus.carry_in},
                 skip_cnt, pc_wr_err);
    endtask

    typedef struct {
        logic [31:0] w;
        logic [3:0]  rd;
        logic [31:0] exp_val;
        logic [2:0]  exp_nzc;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{enc(CC_AL, 1, OP_MOV, 0, 0, 2, 12'h0F0), 4'd2,  32'h0000_00F0, 3'b000};
        tbl[1]  = '{enc(CC_AL, 1, OP_MOV, 0, 0, 3, 12'hF00), 4'd3,  32'h0000_0F00, 3'b000};
        tbl[2]  = '{enc(CC_AL, 0, OP_ORR, 0, 2, 1, 12'h003), 4'd1,  32'h0000_0FF0, 3'b000};
        tbl[3]  = '{enc(CC_AL, 1, OP_MOV, 0, 0, 1, 12'h000), 4'd1,  32'h0000_0000, 3'b000};
        tbl[4]  = '{enc(CC_AL, 1, OP_ORR, 0, 1, 1, 12'h00F), 4'd1,  32'h0000_000F, 3'b000};
        tbl[5]  = '{enc(CC_AL, 1, OP_ORR, 0, 1, 2, 12'h0F0), 4'd2,  32'h0000_00FF, 3'b000};
        tbl[6]  = '{enc(CC_AL, 1, OP_MOV, 0, 0, 4, 12'h005), 4'd4,  32'h0000_0005, 3'b000};
        tbl[7]  = '{enc(CC_AL, 1, OP_CMP, 1, 4, 4, 12'h005), 4'd4,  32'h0000_0005, 3'b011};
        tbl[8]  = '{enc(CC_AL, 1, OP_MOV, 1, 0, 5, 12'h001), 4'd5,  32'h0000_0001, 3'b001};
        tbl[9]  = '{enc(CC_EQ, 1, OP_MOV, 0, 0, 6, 12'h007), 4'd6,  COND_EN ? INIT : 32'h7, 3'b001};
        tbl[10] = '{enc(CC_NE, 1, OP_MOV, 0, 0, 6, 12'h009), 4'd6,  32'h0000_0009, 3'b001};
        tbl[11] = '{enc(CC_AL, 1, OP_MOV, 0, 0, 15, 12'h003), 4'd15, 32'h0000_0000, 3'b001};
        tbl[12] = '{enc(CC_AL, 1, OP_SUB, 1, 5, 7, 12'h001), 4'd7,  32'h0000_0000, 3'b011};
        tbl[13] = '{enc(CC_AL, 0, OP_ADD, 0, 2, 8, 12'h001), 4'd8,  32'h0000_010E, 3'b011};
        tbl[14] = '{enc(CC_AL, 1, OP_MVN, 1, 0, 9, 12'h000), 4'd9,  32'hFFFF_FFFF, 3'b101};
        tbl[15] = '{enc(CC_LT, 1, OP_MOV, 0, 0, 10, 12'h001), 4'd10, 32'h0000_0001, 3'b101};
        tbl[16] = '{enc(CC_GE, 1, OP_MOV, 0, 0, 10, 12'h002), 4'd10, COND_EN ? 32'h1 : 32'h2, 3'b101};

        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        dbg_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_en", 32'(bus.en_inst), 32'd0);
        chk("rst_Rn", bus.Rn, 32'h0);
        chk("rst_Rm", bus.Rm, 32'h0);
        chk("rst_flags", 32'({bus.neg_in, bus.zero_in, bus.carry_in}), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        chk("rst_pc_err", 32'(pc_wr_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1 chk("rst_rf", dbg_data, (i == 15) ? 32'h0 : INIT);
        end

        for (int i = 0; i < 17; i++) begin
            run(tbl[i].w);
            dbg_addr = tbl[i].rd;
            #1;
            chk("tbl_val", dbg_data, tbl[i].exp_val);
            chk("tbl_nzc", 32'({bus.neg_in, bus.zero_in, bus.carry_in}), 32'(tbl[i].exp_nzc));
            if (i >= 11) chk("tbl_pc_err_sticky", 32'(pc_wr_err), 32'd1);
            if (i == 9) chk("tbl_skip_eq", 32'(skip_cnt), COND_EN ? 32'd1 : 32'd0);
        end

        // Reset asserted while the instruction sits in EXEC.
        dbg_addr = 4'd11;
        bus.instr_valid = 1'b1;
        bus.instr = enc(CC_AL, 1, OP_MOV, 1, 0, 11, 12'h055);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_en_before_rst", 32'(bus.en_inst), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_en_in_rst", 32'(bus.en_inst), 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_ready_after_rst", 32'(bus.instr_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_en", 32'(bus.en_inst), 32'd0);
        end
        chk("mid_rf_untouched", dbg_data, INIT);
        chk("mid_flags", 32'({bus.neg_in, bus.zero_in, bus.carry_in}), 32'd0);
        chk("mid_pc_err", 32'(pc_wr_err), 32'd0);
        #1;

        for (int n = 0; n < 80; n++) begin
            logic [31:0] w;
            w = {4'($urandom_range(0, 15)), 2'b00, 1'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 14)), 12'($urandom)};
            run(w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dp_issue.md
# dp_issue

Issue and writeback stage for the data-processing unit. It accepts one 32-bit data-processing instruction word per handshake and reads operands from an internal 16×32 register file. It then drives the operand bus and a one-cycle `en_inst` pulse to the ALU op units (OR, AND and the rest), and writes the selected result and N/Z/C flags back one cycle later. It sits directly upstream of the op units and also consumes what they produce.

## Interface
- `REG_INIT` — default 32'h0 — reset value of R0–R14.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction word present.
- `instr_ready`  out  1  stage can accept (IDLE only).
- `instr`  in  32  [31:28] cond, [25] I, [24:21] opcode, [20] S, [19:16] Rn, [15:12] Rd, [11:0] operand2.
- `en_inst`  out  1  one-cycle execute pulse to op units.
- `opcode`  out  4  selects which op unit's result/flags are consumed.
- `IMM`, `S`  out  1 each  from instr[25], instr[20].
- `Rn`, `Rm`  out  32 each  register-file values (Rm index = operand2[3:0]).
- `imm_operand`  out  12  operand2.
- `imm_shift`  out  5  operand2[11:7].
- `stype`  out  2  operand2[6:5].
- `carry_in`, `zero_in`, `neg_in`  out  1 each  current flags.
- `Rd`  in  32  selected op-unit result.
- `carry_out`, `zero_out`, `neg_out`  in  1 each  selected op-unit flags.
- `dbg_addr`  in  4  asynchronous debug read index.
- `dbg_data`  out  32  regfile[dbg_addr].
- `pc_wr_err`  out  1  sticky: an executed instruction targeted R15.
- `skip_cnt`  out  16  instructions skipped by the condition check.

## Operation
- FSM `IDLE → READ → EXEC → WB → IDLE`. `instr_ready = (state == IDLE)`.
- IDLE: on `instr_valid & instr_ready`, latch `instr` and go to READ.
- READ:
  - Evaluate cond against N/Z/C. V is treated as 0, so GE = !N, LT = N, GT = !Z & !N, LE = Z | N. AL (1110) and NV (1111) always pass.
  - On fail: `skip_cnt++` (saturating at FFFF), return to IDLE, no outputs change.
  - On pass: register all operand outputs, set `en_inst = 1`, go to EXEC.
- EXEC: `en_inst = 0`. Operand outputs are held. Go to WB.
- WB: sample `Rd` and the flags. Then return to IDLE.
  - Regfile write when opcode ∉ {TST 1000, TEQ 1001, CMP 1010, CMN 1011}.
  - Flags (N, Z, C) are always latched from `*_out`; op units already pass the flags through when S = 0.
- Rd index 15: the write is dropped and `pc_wr_err` is set. R15 reads return its reset value 0.
- Register read-before-write: the operands of instruction k+1 see the writeback of instruction k, because the write completes before the next READ.
- Reset: state IDLE, `instr_ready` = 1, `en_inst` = 0, all operand outputs 0, flags 0, R0–R14 = `REG_INIT`, R15 = 0, `skip_cnt` = 0, `pc_wr_err` = 0.
- Reset mid-operation: the instruction is discarded with no register or flag write.

## Timing
- Accept edge at cycle T. READ during T+1. `en_inst` is high during T+2 only.
- WB during T+3; register and flag writes occur on the T+3→T+4 edge.
- `instr_ready` is high again at T+4, giving 4 cycles per executed instruction.
- A skipped instruction takes 2 cycles: `instr_ready` is high at T+2.
- Operand outputs are stable from T+2 through T+3. Op units must produce results within 1 cycle of `en_inst` rising.
- `dbg_data` is combinational from the regfile and reflects writes from the next cycle onward.

## Configuration
- `DP_ISSUE_COND_EN`
  - Defined: conditional execution as above.
  - Undefined: the cond field is ignored, every instruction executes, `skip_cnt` is tied to 0, and the condition logic is removed.

## Structure
- Shared package `dp_pkg`:
  - opcode constants (AND 0000 … MVN 1111);
  - cond constants (EQ 0000 … NV 1111);
  - FSM state enum;
  - instruction field bit positions.
- One sub-module, `cond_check`: combinational (cond, N, Z, C) → pass. It is instantiated only under `DP_ISSUE_COND_EN`.

## Test plan
- Reset then ORR R1,R2,R3 (imm=0) with R2 = 0x00F0, R3 = 0x0F00: `en_inst` high for exactly one cycle at T+2; R1 = 0x0FF0 at T+4; `instr_ready` is low from T+1 to T+3.
- Back-to-back ORR R1,R1,#0x0F then ORR R2,R1,#0xF0 from R1 = 0: R2 = 0xFF, which checks read-after-write.
- CMP-opcode instruction with Rd = R4 and S = 1: R4 unchanged and flags updated from `*_out`.
- With `DP_ISSUE_COND_EN`, Z = 0, cond EQ: no `en_inst` pulse, `skip_cnt` = 1, `instr_ready` high at T+2. Repeating with cond NE executes.
- Instruction with Rd = 15: R15 stays 0 and `pc_wr_err` becomes 1 and stays 1 until `rst`.
- Assert `rst` during EXEC: no write occurs, `en_inst` = 0, `instr_ready` = 1 the cycle after reset deasserts.
